// File: rtl/data_pack_stream.sv
// data_pack_stream: packs 1..LANES valid low-order lanes per input beat into
// dense DATA_W-bit output words, LSB-first, with no gaps between beats.
// A flush emits any residual lanes as a partial word. A flush that arrives
// while a full word is being emitted is deferred by one cycle through
// r_flush_pend. A beat whose lane count exceeds LANES raises lane_err and
// is treated as a LANES-lane beat.
module data_pack_stream #(
  parameter  int DATA_W = 8,
  parameter  int LANE_W = 4,
  localparam int LANES  = DATA_W / LANE_W,
  localparam int CNT_W  = $clog2(LANES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  lane_cnt,
  input  logic              flush,
  output logic [DATA_W-1:0] data_o,
  output logic              data_en,
  output logic [CNT_W-1:0]  data_lanes,
  output logic              lane_err
);

  localparam logic [CNT_W:0]   LANES_T = (CNT_W + 1)'(LANES);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  // Registered state: residual lanes (always packed from lane 0, unused
  // upper lanes kept at zero), their count, the deferred flush and outputs.
  logic [DATA_W-1:0] r_res;
  logic [CNT_W-1:0]  r_res_cnt;
  logic              r_flush_pend;
  logic [DATA_W-1:0] r_data;
  logic              r_en;
  logic [CNT_W-1:0]  r_lanes;
  logic              r_err;

  // Combinational datapath signals.
  logic [CNT_W-1:0]    w_n;
  logic                w_err;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_masked;
  logic [2*DATA_W-1:0] w_comb;
  logic [CNT_W:0]      w_total;
  logic                w_full;
  logic [CNT_W:0]      w_left_wide;
  logic [CNT_W-1:0]    w_left_cnt;
  logic [DATA_W-1:0]   w_left_data;
  logic                w_eff_flush;
  logic                w_emit_part;
  logic [DATA_W-1:0]   w_res_nxt;
  logic [CNT_W-1:0]    w_res_cnt_nxt;
  logic                w_pend_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_en_nxt;
  logic [CNT_W-1:0]    w_lanes_nxt;

  // Clamp the lane count, mask unused lanes, append the beat above the
  // residual, then decide between a full word, a partial flush, or nothing.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_n           = '0;
    w_err         = 1'b0;
    w_mask        = '0;
    w_data_nxt    = r_data;
    w_lanes_nxt   = r_lanes;
    w_en_nxt      = 1'b0;

    if (start) begin
      if ({1'b0, lane_cnt} > LANES_T) begin
        w_n   = LANES_C;
        w_err = 1'b1;
      end else begin
        w_n = lane_cnt;
      end
    end

    // Don't-care lanes (possibly X) are forced to zero so they can never
    // leak into a word or into the residual.
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(w_n)) begin
        w_mask[i*LANE_W +: LANE_W] = '1;
      end
    end
    w_masked = data_in & w_mask;

    w_comb  = {{DATA_W{1'b0}}, r_res}
            | ({{DATA_W{1'b0}}, w_masked} << (LANE_W * int'(r_res_cnt)));
    w_total = {1'b0, r_res_cnt} + {1'b0, w_n};
    w_full  = (w_total >= LANES_T);

    w_left_wide = w_full ? (w_total - LANES_T) : w_total;
    w_left_cnt  = w_left_wide[CNT_W-1:0];
    w_left_data = w_full ? w_comb[2*DATA_W-1:DATA_W] : w_comb[DATA_W-1:0];

    // Flush is judged after packing: with a full word already leaving this
    // cycle, the leftover has to wait for the next cycle.
    w_eff_flush = flush | r_flush_pend;
    w_emit_part = w_eff_flush && !w_full && (w_left_cnt != '0);
    w_pend_nxt  = w_eff_flush && w_full && (w_left_cnt != '0);

    w_res_nxt     = w_emit_part ? '0 : w_left_data;
    w_res_cnt_nxt = w_emit_part ? '0 : w_left_cnt;

    if (w_full) begin
      w_data_nxt  = w_comb[DATA_W-1:0];
      w_lanes_nxt = LANES_C;
      w_en_nxt    = 1'b1;
    end else if (w_emit_part) begin
      w_data_nxt  = w_left_data;
      w_lanes_nxt = w_left_cnt;
      w_en_nxt    = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset; reset
  // discards the residual without emitting it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      r_res        <= '0;
      r_res_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_data       <= '0;
      r_en         <= 1'b0;
      r_lanes      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_res        <= w_res_nxt;
      r_res_cnt    <= w_res_cnt_nxt;
      r_flush_pend <= w_pend_nxt;
      r_data       <= w_data_nxt;
      r_en         <= w_en_nxt;
      r_lanes      <= w_lanes_nxt;
      r_err        <= w_err;
    end
  end

  assign data_o     = r_data;
  assign data_en    = r_en;
  assign data_lanes = r_lanes;
  assign lane_err   = r_err;

endmodule
